win_bram: RTL and testbench

//   Frame buffer for one IMG_H x IMG_W image with a KxK neighbourhood read port.

---
 rtl/win_bram.sv | 153 +++++++++++++++
 tb/tb_win_bram.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_bram.sv
// Single-image frame buffer with raster-order writes and a KxK window read port.
// One window is fetched pixel by pixel from a read-first synchronous RAM.
module win_bram #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int K        = 3,
    parameter int PAD_MODE = 0,
    localparam int XW      = $clog2(IMG_H),
    localparam int YW      = $clog2(IMG_W),
    localparam int OW      = K * K * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              frm_clr,
    output logic              frame_full,
    input  logic              rd_en,
    input  logic [XW-1:0]     addrx,
    input  logic [YW-1:0]     addry,
    output logic              rd_ready,
    output logic              out_valid,
    output logic [OW-1:0]     data_out,
    output logic [1:0]        fsm_state
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int KK    = K * K;
    localparam int IW    = (K > 1) ? $clog2(K) : 1;
    localparam int PW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int RW    = XW + 1;
    localparam int CW    = YW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;
    logic [AW-1:0]     wr_ptr;
    logic              wr_fire;

    logic [1:0]    state;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic [IW-1:0] i_cnt;
    logic [IW-1:0] j_cnt;
    logic          pend;
    logic [PW-1:0] pend_idx;
    logic          pend_zero;
    logic [OW-1:0] shadow;
    logic [OW-1:0] shadow_d;

    logic [RW-1:0] row, row_c;
    logic [CW-1:0] col, col_c;
    logic          oob;
    logic          pad_zero;
    logic [AW-1:0] rd_addr;

    assign wr_fire   = wr_en && !frame_full && !frm_clr;
    assign rd_ready  = (state == S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            frame_full <= 1'b0;
        end else if (frm_clr) begin
            wr_ptr     <= '0;
            frame_full <= 1'b0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == AW'(DEPTH - 1))
                frame_full <= 1'b1;
        end
    end

    // Contents are deliberately not reset; the read is read-first on a same-address write.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr] <= data_in;
        mem_q <= mem[rd_addr];
    end

    // Coordinates carry one extra bit so addrx+i / addry+j cannot wrap back into the image.
    always_comb begin
        row      = {1'b0, win_x} + RW'(i_cnt);
        col      = {1'b0, win_y} + CW'(j_cnt);
        oob      = (row >= RW'(IMG_H)) || (col >= CW'(IMG_W));
        row_c    = (row >= RW'(IMG_H)) ? RW'(IMG_H - 1) : row;
        col_c    = (col >= CW'(IMG_W)) ? CW'(IMG_W - 1) : col;
        pad_zero = (PAD_MODE == 0) && oob;
        rd_addr  = AW'(int'(row_c) * IMG_W + int'(col_c));
    end

    // The pixel returning this cycle is merged here so DONE can publish it without waiting.
    always_comb begin
        shadow_d = shadow;
        if (pend)
            shadow_d[int'(pend_idx) * DATA_W +: DATA_W] = pend_zero ? '0 : mem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            win_x     <= '0;
            win_y     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            pend_zero <= 1'b0;
            shadow    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            shadow    <= shadow_d;
            pend      <= 1'b0;
            out_valid <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (rd_en) begin
                        win_x <= addrx;
                        win_y <= addry;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    pend      <= 1'b1;
                    pend_idx  <= PW'(int'(i_cnt) * K + int'(j_cnt));
                    pend_zero <= pad_zero;
                    if (j_cnt == IW'(K - 1)) begin
                        j_cnt <= '0;
                        if (i_cnt == IW'(K - 1))
                            state <= S_DONE;
                        else
                            i_cnt <= i_cnt + IW'(1);
                    end else begin
                        j_cnt <= j_cnt + IW'(1);
                    end
                end
                S_DONE: begin
                    data_out <= shadow_d;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_win_bram.sv
// Bench for win_bram: zero-pad and clamp instances share stimulus; windows are
// checked against a reference image model through an expected-window queue.
module tb_win_bram;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KK = 3;
    localparam int OW = KK * KK * DW;

    logic          clk = 1'b0;
    logic          rst, wr_en, frm_clr, rd_en;
    logic [DW-1:0] data_in;
    logic [2:0]    addrx, addry;
    logic          frame_full0, rd_ready0, out_valid0;
    logic          frame_full1, rd_ready1, out_valid1;
    logic [OW-1:0] data_out0, data_out1;
    logic [1:0]    fsm_state0, fsm_state1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ref_mem [W*H];
    int            ref_ptr;
    bit            ref_full;
    logic [OW-1:0] exp_q [$];

    always #5 clk = ~clk;

    win_bram #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK), .PAD_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .frm_clr(frm_clr),
        .frame_full(frame_full0), .rd_en(rd_en), .addrx(addrx), .addry(addry),
        .rd_ready(rd_ready0), .out_valid(out_valid0), .data_out(data_out0),
        .fsm_state(fsm_state0)
    );

    win_bram #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK), .PAD_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .frm_clr(frm_clr),
        .frame_full(frame_full1), .rd_en(rd_en), .addrx(addrx), .addry(addry),
        .rd_ready(rd_ready1), .out_valid(out_valid1), .data_out(data_out1),
        .fsm_state(fsm_state1)
    );

    function automatic logic [OW-1:0] win_model(input int x, input int y, input int pad);
        logic [OW-1:0] w;
        logic [DW-1:0] p;
        int r, c;
        w = '0;
        for (int i = 0; i < KK; i++) begin
            for (int j = 0; j < KK; j++) begin
                r = x + i;
                c = y + j;
                if (r >= H || c >= W) begin
                    if (pad == 0) p = '0;
                    else p = ref_mem[((r >= H) ? H - 1 : r) * W + ((c >= W) ? W - 1 : c)];
                end else begin
                    p = ref_mem[r * W + c];
                end
                w[(i * KK + j) * DW +: DW] = p;
            end
        end
        return w;
    endfunction

    task automatic write_px(input logic [DW-1:0] v);
        wr_en   = 1'b1;
        data_in = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (!ref_full) begin
            ref_mem[ref_ptr] = v;
            if (ref_ptr == W * H - 1) ref_full = 1'b1;
            ref_ptr = (ref_ptr + 1) % (W * H);
        end
    endtask

    task automatic issue_read(input int x, input int y, output int lat,
                              output logic [OW-1:0] got0, output logic [OW-1:0] got1);
        addrx = 3'(x);
        addry = 3'(y);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        lat = 1;
        while (!out_valid0 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got0 = data_out0;
        got1 = data_out1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready: got %b expected 1", rd_ready0); end
        n_checks++;
        if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        n_checks++;
        if (data_out0 !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out0); end
        n_checks++;
        if (frame_full0 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_full: got %b expected 0", frame_full0); end
    endtask

    task automatic test_fill;
        for (int k = 0; k < W * H - 1; k++) write_px(DW'(k));
        n_checks++;
        if (frame_full0 !== 1'b0) begin n_fail++; $display("FAIL fill_63_not_full: got %b expected 0", frame_full0); end
        write_px(DW'(W * H - 1));
        n_checks++;
        if (frame_full0 !== 1'b1) begin n_fail++; $display("FAIL fill_64_full: got %b expected 1", frame_full0); end
    endtask

    task automatic test_read_basic;
        int xs [3] = '{0, 5, 2};
        int ys [3] = '{0, 5, 3};
        int lat;
        logic [OW-1:0] g0, g1, e;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back(win_model(xs[t], ys[t], 0));
            issue_read(xs[t], ys[t], lat, g0, g1);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== 11) begin n_fail++; $display("FAIL read_latency(%0d,%0d): got %0d expected 11", xs[t], ys[t], lat); end
            n_checks++;
            if (g0 !== e) begin n_fail++; $display("FAIL read_window(%0d,%0d): got %h expected %h", xs[t], ys[t], g0, e); end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b expected 0", out_valid0); end
            n_checks++;
            if (data_out0 !== e) begin n_fail++; $display("FAIL data_stable: got %h expected %h", data_out0, e); end
        end
    endtask

    task automatic test_pad;
        int xs [2] = '{7, 6};
        int ys [2] = '{7, 0};
        int lat;
        logic [OW-1:0] g0, g1, e, e1;
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back(win_model(xs[t], ys[t], 0));
            e1 = win_model(xs[t], ys[t], 1);
            issue_read(xs[t], ys[t], lat, g0, g1);
            e = exp_q.pop_front();
            n_checks++;
            if (g0 !== e) begin n_fail++; $display("FAIL pad_zero(%0d,%0d): got %h expected %h", xs[t], ys[t], g0, e); end
            n_checks++;
            if (g1 !== e1) begin n_fail++; $display("FAIL pad_clamp(%0d,%0d): got %h expected %h", xs[t], ys[t], g1, e1); end
        end
    endtask

    task automatic test_back_to_back;
        logic [OW-1:0] e;
        bit exp_rdy, exp_vld;
        addrx = 3'd0;
        addry = 3'd0;
        rd_en = 1'b1;
        exp_q.push_back(win_model(0, 0, 0));
        for (int k = 0; k <= 34; k++) begin
            @(posedge clk);
            #1;
            exp_rdy = (k == 10) || (k == 21) || (k >= 32);
            exp_vld = (k == 10) || (k == 21) || (k == 32);
            n_checks++;
            if (rd_ready0 !== exp_rdy) begin n_fail++; $display("FAIL b2b_rd_ready k=%0d: got %b expected %b", k, rd_ready0, exp_rdy); end
            n_checks++;
            if (out_valid0 !== exp_vld) begin n_fail++; $display("FAIL b2b_out_valid k=%0d: got %b expected %b", k, out_valid0, exp_vld); end
            if (out_valid0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_window k=%0d: got %h expected none", k, data_out0);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out0 !== e) begin n_fail++; $display("FAIL b2b_window k=%0d: got %h expected %h", k, data_out0, e); end
                end
            end
            if (k == 3) begin addrx = 3'd5; addry = 3'd5; end
            if (k == 10) exp_q.push_back(win_model(5, 5, 0));
            if (k == 14) begin addrx = 3'd2; addry = 3'd3; end
            if (k == 21) exp_q.push_back(win_model(2, 3, 0));
            if (k == 22) rd_en = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_windows: got %0d left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_full_ignore;
        int lat;
        logic [OW-1:0] g0, g1, e;
        write_px(8'd200);
        n_checks++;
        if (frame_full0 !== 1'b1) begin n_fail++; $display("FAIL full_stays: got %b expected 1", frame_full0); end
        exp_q.push_back(win_model(0, 0, 0));
        issue_read(0, 0, lat, g0, g1);
        e = exp_q.pop_front();
        n_checks++;
        if (g0 !== e) begin n_fail++; $display("FAIL full_no_overwrite: got %h expected %h", g0, e); end
        frm_clr = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'd77;
        @(posedge clk);
        #1;
        frm_clr = 1'b0;
        wr_en   = 1'b0;
        ref_ptr  = 0;
        ref_full = 1'b0;
        n_checks++;
        if (frame_full0 !== 1'b0) begin n_fail++; $display("FAIL clr_frame_full: got %b expected 0", frame_full0); end
        write_px(8'd100);
        n_checks++;
        if (frame_full0 !== 1'b0) begin n_fail++; $display("FAIL after_clr_write_full: got %b expected 0", frame_full0); end
        exp_q.push_back(win_model(0, 0, 0));
        issue_read(0, 0, lat, g0, g1);
        e = exp_q.pop_front();
        n_checks++;
        if (g0 !== e) begin n_fail++; $display("FAIL clr_rewrite_window: got %h expected %h", g0, e); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses;
        logic [OW-1:0] g0, g1, e;
        addrx = 3'd2;
        addry = 3'd3;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        ref_ptr  = 0;
        ref_full = 1'b0;
        n_checks++;
        if (rd_ready0 !== 1'b1) begin n_fail++; $display("FAIL midrst_rd_ready: got %b expected 1", rd_ready0); end
        n_checks++;
        if (data_out0 !== '0) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 0", data_out0); end
        n_checks++;
        if (frame_full0 !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_full: got %b expected 0", frame_full0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (out_valid0) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
        exp_q.push_back(win_model(0, 0, 0));
        issue_read(0, 0, lat, g0, g1);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 11) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 11", lat); end
        n_checks++;
        if (g0 !== e) begin n_fail++; $display("FAIL midrst_window: got %h expected %h", g0, e); end
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        frm_clr  = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        addrx    = '0;
        addry    = '0;
        ref_ptr  = 0;
        ref_full = 1'b0;
        for (int k = 0; k < W * H; k++) ref_mem[k] = '0;
        test_reset();
        test_fill();
        test_read_basic();
        test_pad();
        test_back_to_back();
        test_full_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
